// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single registered borrow, with valid/ready handshakes on both sides.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bo_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bo_q;
  logic             ovf_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic d_bit;
  logic br_next;
  logic last_bit;

  // One-bit full subtractor on the current LSBs of the operand shifters.
  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last_bit = (cnt_q == LAST_CNT);

  // Handshake flags are pure decodes of the state register.
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);

  assign diff_o = diff_q;
  assign bo_o   = bo_q;
  assign ovf_o  = ovf_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid_i)                state_d = RUN;
      RUN:  if (last_bit)                  state_d = DONE;
      DONE: if (out_ready_i)               state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath. Every register is cleared by reset so an aborted operation
  // leaves no trace in the visible result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            br_q    <= bin_i;
            a_msb_q <= a_i[WIDTH-1];
            b_msb_q <= b_i[WIDTH-1];
            cnt_q   <= '0;
          end
        end
        RUN: begin
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_q    <= {1'b0, a_q[WIDTH-1:1]};
          b_q    <= {1'b0, b_q[WIDTH-1:1]};
          br_q   <= br_next;
          cnt_q  <= cnt_q + 1'b1;
          // On the MSB step d_bit is the result sign; latch the flags here so
          // they stay stable through DONE and persist in IDLE.
          if (last_bit) begin
            bo_q  <= br_next;
            ovf_q <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
